// File: rtl/alu_packet_sequencer.sv
// Serial front-end for the 32-bit ALU core: deframes 11-bit frames, assembles B/A,
// validates the command frame (count, CRC4, opcode) and issues one transaction or an error byte.
module alu_packet_sequencer #(
    parameter int unsigned DATA_FRAMES = 8,
    parameter logic [3:0]  CRC_INIT    = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [7:0]  CTL,
    output logic        valid,
    output logic        busy
);

    localparam int unsigned CNT_W    = $clog2(DATA_FRAMES + 2);
    localparam int unsigned SLOTS    = 8;
    localparam int unsigned SLOT_W   = 3;
    localparam int unsigned BCNT_W   = 4;
    localparam int unsigned MSG_W    = 68;
    localparam logic [BCNT_W-1:0] STOP_IDX = BCNT_W'(9);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DATA_FRAMES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RX   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BCNT_W-1:0]   r_bitcnt;
    logic [8:0]          r_shift;
    logic                w_frame_done;

    logic [CNT_W-1:0]    r_cnt;
    logic                r_err_data;
    logic [7:0]          r_slot [SLOTS];

    logic                r_cmd_pend;
    logic                r_cmd_bad;
    logic [2:0]          r_cmd_op;
    logic [3:0]          r_cmd_crc;

    logic                r_iss_pend;
    logic                r_iss_ok;
    logic [7:0]          r_iss_ctl;

    logic [31:0]         w_shadow_b;
    logic [31:0]         w_shadow_a;
    logic [3:0]          w_crc;
    logic                w_ed;
    logic                w_ec;
    logic                w_eo;
    logic [6:0]          w_err_hi;

    // Serial CRC4, polynomial x^4+x+1, MSB of the message first
    function automatic logic [3:0] crc4_calc(input logic [MSG_W-1:0] msg);
        logic [3:0] c;
        logic       fb;
        c = CRC_INIT;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            busy    <= (w_state_next == S_RX);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (!sin) w_state_next = S_RX;
            S_RX:   if (r_bitcnt == STOP_IDX) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_frame_done = (r_state == S_RX) && (r_bitcnt == STOP_IDX);

    // Bit counter and shift register: after nine RX bits r_shift = {type, d[7:0]}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else if (r_state == S_IDLE) begin
            r_bitcnt <= '0;
        end else begin
            r_bitcnt <= r_bitcnt + BCNT_W'(1);
            r_shift  <= {r_shift[7:0], sin};
        end
    end

    assign w_shadow_b = {r_slot[0], r_slot[1], r_slot[2], r_slot[3]};
    assign w_shadow_a = {r_slot[4], r_slot[5], r_slot[6], r_slot[7]};
    assign w_crc      = crc4_calc({w_shadow_b, w_shadow_a, 1'b1, r_cmd_op});
    assign w_ed       = (r_cnt != CNT_FULL) || r_err_data || r_cmd_bad;
    assign w_ec       = !w_ed && (w_crc != r_cmd_crc);
    assign w_eo       = !w_ed && !w_ec && r_cmd_op[1];
    assign w_err_hi   = {1'b1, w_ed, w_ec, w_eo, w_ed, w_ec, w_eo};

    // Packet assembly and the evaluation stage one cycle after a command frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_err_data <= 1'b0;
            for (int i = 0; i < int'(SLOTS); i++) r_slot[i] <= '0;
            r_cmd_pend <= 1'b0;
            r_cmd_bad  <= 1'b0;
            r_cmd_op   <= '0;
            r_cmd_crc  <= '0;
            r_iss_pend <= 1'b0;
            r_iss_ok   <= 1'b0;
            r_iss_ctl  <= '0;
        end else begin
            r_iss_pend <= 1'b0;
            if (r_cmd_pend) begin
                r_iss_pend <= 1'b1;
                r_iss_ok   <= !(w_ed || w_ec || w_eo);
                r_iss_ctl  <= (w_ed || w_ec || w_eo) ? {w_err_hi, ^w_err_hi}
                                                     : {1'b0, r_cmd_op, r_cmd_crc};
                r_cnt      <= '0;
                r_err_data <= 1'b0;
                r_cmd_pend <= 1'b0;
                r_cmd_bad  <= 1'b0;
            end
            if (w_frame_done) begin
                if (r_shift[8]) begin
                    r_cmd_pend <= 1'b1;
                    r_cmd_bad  <= !sin;
                    r_cmd_op   <= r_shift[6:4];
                    r_cmd_crc  <= r_shift[3:0];
                end else if (!sin) begin
                    r_err_data <= 1'b1;
                end else begin
                    if (r_cnt < CNT_W'(SLOTS)) r_slot[r_cnt[SLOT_W-1:0]] <= r_shift[7:0];
                    if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Issue: operands only move on a clean command; CTL always reports the outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A     <= '0;
            B     <= '0;
            CTL   <= 8'hFF;
            valid <= 1'b0;
        end else begin
            valid <= r_iss_pend;
            if (r_iss_pend) begin
                CTL <= r_iss_ctl;
                if (r_iss_ok) begin
                    A <= w_shadow_a;
                    B <= w_shadow_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_packet_sequencer.sv
// Bench for alu_packet_sequencer: packet-level reference model, per-cycle output compare,
// directed test-plan packets and randomized packets.
module tb_alu_packet_sequencer;

    localparam logic [3:0] TB_CRC_INIT = 4'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic [31:0] A;
    logic [31:0] B;
    logic [7:0]  CTL;
    logic        valid;
    logic        busy;

    alu_packet_sequencer #(
        .DATA_FRAMES (8),
        .CRC_INIT    (TB_CRC_INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .A     (A),
        .B     (B),
        .CTL   (CTL),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int unsigned cyc;
        logic        ok;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  ctl;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  pkt_bytes[$];
    bit          pkt_err = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [7:0]  m_ctl = 8'hFF;
    int unsigned v_last = 0;
    int unsigned v_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC as the remainder of polynomial long division of (seeded message * x^4) by x^4+x+1
    function automatic logic [3:0] model_crc(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg ^ {TB_CRC_INIT, 64'h0}, 4'h0};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [7:0] err_ctl(input bit ed, input bit ec, input bit eo);
        logic [6:0] h;
        h = {1'b1, ed, ec, eo, ed, ec, eo};
        return {h, ^h};
    endfunction

    // Packet-level model: collect data bytes, judge the packet when its command arrives
    task automatic model_frame(input bit typ, input logic [7:0] d, input bit ok, input int unsigned k);
        exp_t e;
        bit ed, ec, eo;
        logic [3:0] c;
        if (!typ) begin
            if (!ok) pkt_err = 1'b1;
            else pkt_bytes.push_back(d);
        end else begin
            ed = pkt_err || !ok || (pkt_bytes.size() != 8);
            ec = 1'b0;
            eo = 1'b0;
            e.a = '0;
            e.b = '0;
            if (!ed) begin
                e.b = {pkt_bytes[0], pkt_bytes[1], pkt_bytes[2], pkt_bytes[3]};
                e.a = {pkt_bytes[4], pkt_bytes[5], pkt_bytes[6], pkt_bytes[7]};
                c = model_crc({e.b, e.a, 1'b1, d[6:4]});
                ec = (c != d[3:0]);
                eo = !ec && !(d[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101});
            end
            e.ok  = !(ed || ec || eo);
            e.ctl = e.ok ? {1'b0, d[6:0]} : err_ctl(ed, ec, eo);
            e.cyc = k + 3;
            q.push_back(e);
            pkt_bytes.delete();
            pkt_err = 1'b0;
        end
    endtask

    task automatic model_reset();
        q.delete();
        pkt_bytes.delete();
        pkt_err = 1'b0;
        m_a = '0;
        m_b = '0;
        m_ctl = 8'hFF;
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input bit typ, input logic [7:0] d, input bit stop_ok);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop_ok);
        model_frame(typ, d, stop_ok, cyc);
        if (!stop_ok) send_bit(1'b1);
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                               input logic [3:0] crc_xor, input int nfr, input int gap,
                               input int bad_pct);
        logic [63:0] ba;
        logic [7:0]  d;
        logic [3:0]  c;
        bit          bad;
        ba = {b, a};
        for (int i = 0; i < nfr; i++) begin
            idle(gap);
            d = (i < 8) ? ba[63 - 8*i -: 8] : 8'($urandom);
            bad = (int'($urandom_range(0, 99)) < bad_pct);
            send_frame(1'b0, d, !bad);
        end
        c = model_crc({b, a, 1'b1, op}) ^ crc_xor;
        idle(gap);
        send_frame(1'b1, {1'b0, op, c}, 1'b1);
    endtask

    // Per-cycle compare of the strobe timing and the held A/B/CTL values
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("valid_strobe", 64'(valid), 64'(1));
                m_ctl = q[0].ctl;
                if (q[0].ok) begin
                    m_a = q[0].a;
                    m_b = q[0].b;
                end
                v_prev = v_last;
                v_last = cyc;
                void'(q.pop_front());
            end else begin
                check("valid_quiet", 64'(valid), 64'(0));
            end
            check("A_hold", 64'(A), 64'(m_a));
            check("B_hold", 64'(B), 64'(m_b));
            check("CTL_hold", 64'(CTL), 64'(m_ctl));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int nfr;
        int r;
        logic [2:0] op;
        logic [3:0] cx;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_A", 64'(A), 64'(0));
        check("rst_B", 64'(B), 64'(0));
        check("rst_CTL", 64'(CTL), 64'(8'hFF));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        #1 rst_n = 1'b1;
        idle(3);

        check("model_crc_add", 64'(model_crc({32'h1, 32'h2, 1'b1, 3'b100})), 64'(4'hA));
        check("model_err_crc", 64'(err_ctl(1'b0, 1'b1, 1'b0)), 64'(8'hA5));
        check("model_err_data", 64'(err_ctl(1'b1, 1'b0, 1'b0)), 64'(8'hC9));
        check("model_err_op", 64'(err_ctl(1'b0, 1'b0, 1'b1)), 64'(8'h93));

        send_packet(32'h1, 32'h2, 3'b100, 4'h0, 8, 0, 0);
        idle(5);
        check("add_A", 64'(A), 64'(32'h2));
        check("add_B", 64'(B), 64'(32'h1));
        check("add_CTL", 64'(CTL), 64'(8'h4A));
        check("idle_busy", 64'(busy), 64'(0));

        send_packet(32'h1, 32'h2, 3'b100, 4'h1, 8, 1, 0);
        idle(5);
        check("crc_err_CTL", 64'(CTL), 64'(8'hA5));
        check("crc_err_A", 64'(A), 64'(32'h2));

        send_packet(32'hCAFEF00D, 32'h0BADBEEF, 3'b000, 4'h0, 7, 0, 0);
        idle(5);
        check("cnt7_CTL", 64'(CTL), 64'(8'hC9));
        check("cnt7_B", 64'(B), 64'(32'h1));

        send_packet(32'hCAFEF00D, 32'h0BADBEEF, 3'b000, 4'h0, 9, 0, 0);
        idle(5);
        check("cnt9_CTL", 64'(CTL), 64'(8'hC9));

        send_packet(32'h11223344, 32'h55667788, 3'b111, 4'h0, 8, 0, 0);
        idle(5);
        check("badop_CTL", 64'(CTL), 64'(8'h93));
        check("badop_A", 64'(A), 64'(32'h2));

        send_packet(32'h0, 32'h0, 3'b001, 4'h0, 0, 0, 0);
        idle(5);
        check("nodata_CTL", 64'(CTL), 64'(8'hC9));

        // Asynchronous reset during bit 5 of the third frame
        send_frame(1'b0, 8'hA5, 1'b1);
        send_frame(1'b0, 8'h5A, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #1 check("rx_busy", 64'(busy), 64'(1));
        #1 rst_n = 1'b0;
        sin = 1'b1;
        model_reset();
        #1;
        check("midrst_A", 64'(A), 64'(0));
        check("midrst_B", 64'(B), 64'(0));
        check("midrst_CTL", 64'(CTL), 64'(8'hFF));
        check("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        send_packet(32'hDEADBEEF, 32'h12345678, 3'b001, 4'h0, 8, 0, 0);
        idle(5);
        check("postrst_A", 64'(A), 64'(32'h12345678));
        check("postrst_B", 64'(B), 64'(32'hDEADBEEF));
        check("postrst_CTL_hi", 64'(CTL[7:4]), 64'(4'b0001));

        send_packet(32'h01020304, 32'h05060708, 3'b101, 4'h0, 8, 0, 0);
        send_packet(32'hF0E0D0C0, 32'hB0A09080, 3'b000, 4'h0, 8, 0, 0);
        idle(5);
        check("b2b_spacing", 64'(v_last - v_prev), 64'(99));
        check("b2b_A", 64'(A), 64'(32'hB0A09080));

        for (int p = 0; p < 40; p++) begin
            r = int'($urandom_range(0, 9));
            nfr = (r < 7) ? 8 : (r == 7) ? 7 : (r == 8) ? 9 : 0;
            op = 3'($urandom);
            cx = (int'($urandom_range(0, 4)) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            send_packet($urandom, $urandom, op, cx, nfr, int'($urandom_range(0, 2)), 4);
            idle(int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(q.size()), 64'(0));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_packet_sequencer.md
Name: alu_packet_sequencer

Overview:
Front-end controller for the 32-bit ALU core. It receives the serial command stream one bit per clock and deframes it into 11-bit frames. It assembles operands B and A from eight data frames and validates the command frame (frame count, CRC4, opcode). It then issues one A/B/CTL transaction to the core with a single-cycle valid strobe, or issues an error CTL byte instead.

Parameters:
DATA_FRAMES, 8, data frames required per packet (4 bytes of B, then 4 bytes of A)
CRC_INIT, 4'h0, CRC4 seed value

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sin  input  1  serial command stream; idle high; one bit per clk
A  output  32  operand A to core
B  output  32  operand B to core
CTL  output  8  control byte to core
valid  output  1  one-cycle strobe; A/B/CTL are valid this cycle
busy  output  1  high while a frame is being received

Behaviour:
- Reset (async, rst_n=0): A=0, B=0, CTL=8'hFF, valid=0, busy=0, frame counter=0, FSM=IDLE. Reset mid-frame or mid-packet discards all partial data.
- Frame format, in sin order: start(0), type (0=data, 1=cmd), d[7:0] MSB first, stop(1). That is 11 clocks total.
- FSM states:
  - IDLE: sin=0 -> RX with bit count=0. busy=1 from the next cycle.
  - RX: shift in 10 bits.
  - After the stop bit is sampled (cycle T) -> IDLE. A new start bit is accepted at T+1, so back-to-back frames are legal.
- Stop bit = 0: the frame is marked bad and the packet error flag ERR_DATA is latched. The FSM still returns to IDLE.
- Data frame:
  - Byte goes to slot cnt: slots 0..3 fill B[31:24]..B[7:0]; slots 4..7 fill A[31:24]..A[7:0].
  - cnt increments and saturates at DATA_FRAMES+1.
  - Data frames are written into a shadow register, so A/B outputs do not change until issue.
- Cmd frame: byte = {0, OP[2:0], CRC[3:0]}. Evaluation is done in an issue stage at T+1, in parallel with the RX FSM, in this priority order:
  1. cnt != DATA_FRAMES, or ERR_DATA latched -> error ERR_DATA.
  2. CRC mismatch -> ERR_CRC. CRC4 uses polynomial x^4+x+1, init CRC_INIT, over the 68-bit word {B,A,1'b1,OP}, MSB first.
  3. OP not in {000,001,100,101} -> ERR_OP.
  4. Otherwise OK.
- Issue, registered at T+2:
  - On OK: A/B are loaded from the shadow register, CTL={1'b0,OP,CRC}, valid=1.
  - On error: A/B are unchanged, CTL={1'b1,ED,EC,EO,ED,EC,EO,P}, where P = XOR of CTL[7:1], and valid=1.
  - In both cases cnt and error flags are cleared.
- valid is high for exactly one cycle per cmd frame. A/B/CTL hold their values until the next issue.
- Data frames arriving after the cmd frame start a new packet.
- A cmd frame with no preceding data frames gives ERR_DATA.
- More than 8 data frames gives ERR_DATA; the extra bytes are discarded, not wrapped.
- The only arithmetic is CRC4; there is no ALU logic in this block.

Test Plan:
- Reset mid-RX: pulse rst_n low asynchronously during bit 5 of frame 3 -> outputs go to reset values immediately; a following full valid packet issues normally.
- Valid ADD packet: send B=32'h00000001, A=32'h00000002, OP=100, CRC from model -> valid=1 exactly 2 clocks after the cmd stop bit; A=2, B=1, CTL=8'b0100_cccc.
- CRC error: same packet with CRC XOR 4'h1 -> CTL=8'b1010_0101 (ED=0, EC=1, EO=0, P=1 per formula), A/B unchanged.
- Frame count: 7 data frames + cmd -> CTL=8'b1100_1001. 9 data frames + cmd -> same CTL.
- Bad opcode OP=111 with correct CRC -> CTL=8'b1001_0011.
- Back-to-back: two valid packets with zero idle cycles between frames -> two valid strobes, 99 clocks apart, each with correct A/B/CTL.
